// File: rtl/wave_capture_pkg.sv
// Shared types and helpers for the wave capture block: FSM encoding,
// default geometry, and the sample-to-display conversion.
package wave_capture_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DECIMATE_DEF = 2;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_t;

  // Signed top byte to offset binary: flipping the sign bit maps -128..127 to 0..255.
  function automatic logic [7:0] to_offset_binary(input logic [7:0] top8);
    return {~top8[7], top8[6:0]};
  endfunction

endpackage

// File: rtl/wave_capture_ram.sv
// Ping-pong waveform storage: 2^(ADDR_W+1) x 8, one synchronous write port and
// one registered read port. The array is not reset so it maps onto block RAM.
module wave_capture_ram #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [ADDR_W:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [ADDR_W:0] raddr,
  output logic [7:0]      rdata
);

  logic [7:0] mem [2**(ADDR_W+1)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= 8'h00;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/wave_capture.sv
// Captures audio samples into one half of a ping-pong buffer, triggered on a
// rising zero crossing, and hands the filled half to the display on vsync.
//
// state  | meaning
// ARMED  | waiting for a rising zero crossing (or timeout forced start)
// ACTIVE | storing every DECIMATE-th sample into the capture half
// FULL   | capture half complete, waiting for a vsync rising edge to swap
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DECIMATE = DECIMATE_DEF,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                vsync,
  input  logic [ADDR_W-1:0]   read_addr,
  output logic [7:0]          read_value,
  output logic                display_buf,
  output logic                swap,
  output logic                capturing
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DECIMATE + 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] write_addr, write_addr_next, wr_lo;
  logic [DW-1:0]     decim_cnt, decim_cnt_next;
  logic [TW-1:0]     timeout_cnt, timeout_cnt_next;
  logic              prev_msb, vsync_q;
  logic              display_buf_next, swap_next, we;
  logic              msb, vsync_rise, trigger;

  // Low sample bits fall below display resolution.
  logic sample_unused;
  assign sample_unused = ^sample[SAMPLE_W-9:0];

  assign msb        = sample[SAMPLE_W-1];
  assign vsync_rise = vsync && !vsync_q;
  assign trigger    = new_sample &&
                      ((prev_msb && !msb) || (timeout_cnt == TW'(TIMEOUT - 1)));

  always_comb begin
    state_next       = state;
    write_addr_next  = write_addr;
    decim_cnt_next   = decim_cnt;
    timeout_cnt_next = timeout_cnt;
    display_buf_next = display_buf;
    swap_next        = 1'b0;
    we               = 1'b0;
    wr_lo            = write_addr;
    case (state)
      ARMED: begin
        if (trigger) begin
          we               = 1'b1;
          wr_lo            = '0;
          write_addr_next  = ADDR_W'(1);
          decim_cnt_next   = '0;
          timeout_cnt_next = '0;
          state_next       = ACTIVE;
        end else if (new_sample) begin
          timeout_cnt_next = timeout_cnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (new_sample) begin
          if (decim_cnt == DW'(DECIMATE - 1)) begin
            we              = 1'b1;
            write_addr_next = write_addr + 1'b1;
            decim_cnt_next  = '0;
            if (&write_addr) state_next = FULL;
          end else begin
            decim_cnt_next = decim_cnt + 1'b1;
          end
        end
      end
      FULL: begin
        if (vsync_rise) begin
          display_buf_next = ~display_buf;
          swap_next        = 1'b1;
          timeout_cnt_next = '0;
          state_next       = ARMED;
        end
      end
      default: state_next = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARMED;
      write_addr  <= '0;
      decim_cnt   <= '0;
      timeout_cnt <= '0;
      prev_msb    <= 1'b0;
      vsync_q     <= 1'b0;
      display_buf <= 1'b0;
      swap        <= 1'b0;
      capturing   <= 1'b0;
    end else begin
      state       <= state_next;
      write_addr  <= write_addr_next;
      decim_cnt   <= decim_cnt_next;
      timeout_cnt <= timeout_cnt_next;
      if (new_sample) prev_msb <= msb;
      vsync_q     <= vsync;
      display_buf <= display_buf_next;
      swap        <= swap_next;
      capturing   <= (state_next == ACTIVE);
    end
  end

  wave_capture_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr ({~display_buf, wr_lo}),
    .wdata (to_offset_binary(sample[SAMPLE_W-1 -: 8])),
    .raddr ({display_buf, read_addr}),
    .rdata (read_value)
  );

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: instance 0 uses DECIMATE=2, instance 1 uses
// DECIMATE=1; both use TIMEOUT=16. Expected values are hand-computed.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        ns  [2];
  logic [15:0] smp [2];
  logic        vs  [2];
  logic [7:0]  ra  [2];
  logic [7:0]  rv  [2];
  logic        db  [2];
  logic        sw  [2];
  logic        cap [2];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wave_capture #(.SAMPLE_W(16), .ADDR_W(8), .DECIMATE(2), .TIMEOUT(16)) dut_a (
    .clk(clk), .reset(rst[0]), .new_sample(ns[0]), .sample(smp[0]), .vsync(vs[0]),
    .read_addr(ra[0]), .read_value(rv[0]), .display_buf(db[0]), .swap(sw[0]),
    .capturing(cap[0])
  );

  wave_capture #(.SAMPLE_W(16), .ADDR_W(8), .DECIMATE(1), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(rst[1]), .new_sample(ns[1]), .sample(smp[1]), .vsync(vs[1]),
    .read_addr(ra[1]), .read_value(rv[1]), .display_buf(db[1]), .swap(sw[1]),
    .capturing(cap[1])
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [15:0] v);
    smp[i] = v;
    ns[i]  = 1'b1;
    tick();
    ns[i]  = 1'b0;
    tick();
  endtask

  task automatic read_chk(input int i, input logic [7:0] addr, input logic [7:0] exp,
                          input string tag);
    ra[i] = addr;
    tick();
    check(tag, rv[i], exp);
  endtask

  task automatic vsync_swap(input int i, input logic exp_db, input string tag);
    vs[i] = 1'b1;
    tick();
    check({tag, "_swap"}, {7'd0, sw[i]}, 8'd1);
    check({tag, "_db"}, {7'd0, db[i]}, {7'd0, exp_db});
    vs[i] = 1'b0;
    tick();
    check({tag, "_swap_end"}, {7'd0, sw[i]}, 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; ns[i] = 1'b0; smp[i] = '0; vs[i] = 1'b0; ra[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_read_value", rv[i], 8'h00);
      check("rst_display_buf", {7'd0, db[i]}, 8'd0);
      check("rst_swap", {7'd0, sw[i]}, 8'd0);
      check("rst_capturing", {7'd0, cap[i]}, 8'd0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    // Trigger on rising crossing, then reset mid-capture.
    send(0, 16'hFF00);
    check("no_trig_negative", {7'd0, cap[0]}, 8'd0);
    send(0, 16'h0100);
    check("trig_capturing", {7'd0, cap[0]}, 8'd1);
    send(0, 16'h0200);
    send(0, 16'h0300);
    rst[0] = 1'b1;
    tick();
    check("midrst_capturing", {7'd0, cap[0]}, 8'd0);
    check("midrst_display_buf", {7'd0, db[0]}, 8'd0);
    check("midrst_read_value", rv[0], 8'h00);
    check("midrst_swap", {7'd0, sw[0]}, 8'd0);
    rst[0] = 1'b0;
    tick();

    // Ramp capture with DECIMATE=2: 1 trigger + 510 samples fill 256 entries.
    send(0, 16'hFF00);
    for (int k = 0; k < 510; k++) send(0, 16'(k * 256));
    check("ramp_still_active", {7'd0, cap[0]}, 8'd1);
    send(0, 16'(510 * 256));
    check("ramp_full", {7'd0, cap[0]}, 8'd0);
    send(0, 16'h7FFF);
    vsync_swap(0, 1'b1, "ramp");
    read_chk(0, 8'd0, 8'h80, "ramp_a0");
    read_chk(0, 8'd1, 8'h82, "ramp_a1");
    read_chk(0, 8'd2, 8'h84, "ramp_a2");
    read_chk(0, 8'd255, 8'h7E, "ramp_a255");

    // Vsync edge while ACTIVE is ignored.
    send(0, 16'hFF00);
    send(0, 16'h0000);
    check("act2_capturing", {7'd0, cap[0]}, 8'd1);
    read_chk(0, 8'd0, 8'h80, "act2_pre_a0");
    vs[0] = 1'b1;
    tick();
    check("act_vsync_swap", {7'd0, sw[0]}, 8'd0);
    check("act_vsync_db", {7'd0, db[0]}, 8'd1);
    vs[0] = 1'b0;
    tick();
    check("act_vsync_read", rv[0], 8'h80);
    check("act_vsync_capturing", {7'd0, cap[0]}, 8'd1);
    for (int k = 0; k < 510; k++) send(0, 16'h4000);
    check("act2_full", {7'd0, cap[0]}, 8'd0);
    vsync_swap(0, 1'b0, "act2");
    read_chk(0, 8'd0, 8'h80, "act2_a0");
    read_chk(0, 8'd1, 8'hC0, "act2_a1");
    read_chk(0, 8'd255, 8'hC0, "act2_a255");

    // Next capture, then crossing sample coincident with vsync edge in FULL.
    send(0, 16'hFF00);
    send(0, 16'h0100);
    for (int k = 0; k < 510; k++) send(0, 16'h2000);
    check("sim_full", {7'd0, cap[0]}, 8'd0);
    send(0, 16'hFF00);
    smp[0] = 16'h0100;
    ns[0]  = 1'b1;
    vs[0]  = 1'b1;
    tick();
    check("sim_swap", {7'd0, sw[0]}, 8'd1);
    check("sim_db", {7'd0, db[0]}, 8'd1);
    ns[0] = 1'b0;
    vs[0] = 1'b0;
    tick();
    tick();
    check("sim_no_trigger", {7'd0, cap[0]}, 8'd0);
    read_chk(0, 8'd1, 8'hA0, "sim_a1");
    send(0, 16'hFF00);
    send(0, 16'h0100);
    check("sim_next_trigger", {7'd0, cap[0]}, 8'd1);

    // Timeout forced start on instance 1 with a constant positive sample.
    for (int n = 0; n < 15; n++) send(1, 16'h1000);
    check("to_not_yet", {7'd0, cap[1]}, 8'd0);
    send(1, 16'h1000);
    check("to_forced", {7'd0, cap[1]}, 8'd1);
    for (int n = 0; n < 255; n++) send(1, 16'h1000);
    check("to_full", {7'd0, cap[1]}, 8'd0);
    vsync_swap(1, 1'b1, "to");
    read_chk(1, 8'd0, 8'h90, "to_a0");
    read_chk(1, 8'd100, 8'h90, "to_a100");
    read_chk(1, 8'd255, 8'h90, "to_a255");

    // DECIMATE=1 boundary: 256 samples fill, the 257th is dropped.
    send(1, 16'hFF00);
    for (int i = 0; i < 255; i++) send(1, 16'(i * 256));
    check("dec1_active_255", {7'd0, cap[1]}, 8'd1);
    send(1, 16'(255 * 256));
    check("dec1_full_256", {7'd0, cap[1]}, 8'd0);
    send(1, 16'h4000);
    vsync_swap(1, 1'b0, "dec1");
    read_chk(1, 8'd0, 8'h80, "dec1_a0");
    read_chk(1, 8'd1, 8'h81, "dec1_a1");
    read_chk(1, 8'd255, 8'h7F, "dec1_a255");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
